// File: rtl/case_9_arb_pkg.sv
// Shared defaults for the case_9 multiplier-sharing arbiter and its multiply core.
// Widths and requester count live here so clients and the arbiter agree on packing.
package case_9_arb_pkg;

  localparam int unsigned DefNumReq    = 4;
  localparam int unsigned DefDin0Width = 4;
  localparam int unsigned DefDin1Width = 3;
  localparam int unsigned DefDoutWidth = 4;
  localparam int unsigned DefIdWidth   = (DefNumReq > 1) ? $clog2(DefNumReq) : 1;

endpackage

// File: rtl/case_9_mul_core.sv
// Combinational signed multiply; the result keeps only the low DOUT_WIDTH bits
// of the full-width two's-complement product.
module case_9_mul_core
  import case_9_arb_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = DefDin0Width,
  parameter int unsigned DIN1_WIDTH = DefDin1Width,
  parameter int unsigned DOUT_WIDTH = DefDoutWidth
) (
  input  logic [DIN0_WIDTH-1:0] a_i,
  input  logic [DIN1_WIDTH-1:0] b_i,
  output logic [DOUT_WIDTH-1:0] prod_o
);

  localparam int unsigned FullWidth = DIN0_WIDTH + DIN1_WIDTH;

  logic [FullWidth-1:0] a_ext;
  logic [FullWidth-1:0] b_ext;
  logic [FullWidth-1:0] full;

  // Sign-extend both operands so an unsigned multiply yields the signed product bits.
  assign a_ext  = {{DIN1_WIDTH{a_i[DIN0_WIDTH-1]}}, a_i};
  assign b_ext  = {{DIN0_WIDTH{b_i[DIN1_WIDTH-1]}}, b_i};
  assign full   = a_ext * b_ext;
  assign prod_o = full[DOUT_WIDTH-1:0];

  if (DOUT_WIDTH < FullWidth) begin : gen_trunc
    logic unused_hi;
    assign unused_hi = ^full[FullWidth-1:DOUT_WIDTH];
  end

endmodule

// File: rtl/case_9_mul_share_arb.sv
// Round-robin arbiter sharing one signed multiplier among NUM_REQ requesters,
// with an operand stage (s1) and a product stage (s2) under response backpressure.
module case_9_mul_share_arb
  import case_9_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DefNumReq,
  parameter int unsigned ID_WIDTH   = DefIdWidth,
  parameter int unsigned DIN0_WIDTH = DefDin0Width,
  parameter int unsigned DIN1_WIDTH = DefDin1Width,
  parameter int unsigned DOUT_WIDTH = DefDoutWidth
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_b,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_WIDTH-1:0]              rsp_id,
  output logic [DOUT_WIDTH-1:0]            rsp_data,
  output logic                             busy
);

  logic                  s1_valid_q;
  logic [DIN0_WIDTH-1:0] s1_a_q;
  logic [DIN1_WIDTH-1:0] s1_b_q;
  logic [ID_WIDTH-1:0]   s1_id_q;
  logic                  s2_valid_q;
  logic [ID_WIDTH-1:0]   s2_id_q;
  logic [DOUT_WIDTH-1:0] s2_data_q;
  logic [ID_WIDTH-1:0]   ptr_q;
  logic [ID_WIDTH-1:0]   ptr_d;

  logic                  s2_load;
  logic                  accept;
  logic                  handshake;
  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_idx;
  int unsigned           grant_off;
  int unsigned           grant_sum;
  logic [DIN0_WIDTH-1:0] sel_a;
  logic [DIN1_WIDTH-1:0] sel_b;
  logic [DOUT_WIDTH-1:0] prod;

  logic [2*NUM_REQ-1:0]  dbl_valid;
  logic [2*NUM_REQ-1:0]  rot_valid;

  assign s2_load = s1_valid_q & (~s2_valid_q | rsp_ready);
  assign accept  = ~s1_valid_q | s2_load;

  // Rotating a doubled copy puts the pointer's requester at bit 0, giving wrap-around order.
  assign dbl_valid = {req_valid, req_valid};
  assign rot_valid = dbl_valid >> ptr_q;

  always_comb begin
    grant_found = 1'b0;
    grant_off   = 0;
    grant_sum   = 0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && rot_valid[k]) begin
        grant_found = 1'b1;
        grant_off   = k;
      end
    end
    grant_sum = 32'(ptr_q) + grant_off;
    if (grant_sum >= NUM_REQ) begin
      grant_sum = grant_sum - NUM_REQ;
    end
    grant_idx = ID_WIDTH'(grant_sum);
  end

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_WIDTH'(i)) begin
        req_ready[i] = accept & grant_found & ~ap_rst;
        sel_a        = req_a[i*DIN0_WIDTH +: DIN0_WIDTH];
        sel_b        = req_b[i*DIN1_WIDTH +: DIN1_WIDTH];
      end
    end
  end

  assign handshake = |req_ready;

  always_comb begin
    ptr_d = ptr_q;
    if (handshake) begin
      ptr_d = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  case_9_mul_core #(
    .DIN0_WIDTH(DIN0_WIDTH),
    .DIN1_WIDTH(DIN1_WIDTH),
    .DOUT_WIDTH(DOUT_WIDTH)
  ) u_mul_core (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .prod_o(prod)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_data_q  <= '0;
      ptr_q      <= '0;
    end else begin
      ptr_q <= ptr_d;
      // s1 empties when it shifts into s2 without a new grant behind it.
      if (accept) begin
        s1_valid_q <= handshake;
      end
      if (handshake) begin
        s1_a_q  <= sel_a;
        s1_b_q  <= sel_b;
        s1_id_q <= grant_idx;
      end
      if (s2_load) begin
        s2_valid_q <= 1'b1;
        s2_id_q    <= s1_id_q;
        s2_data_q  <= prod;
      end else if (rsp_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_id    = s2_id_q;
  assign rsp_data  = s2_data_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_case_9_mul_share_arb.sv
// Bench for case_9_mul_share_arb: directed scenarios plus random traffic against
// a queue-based reference model of the shared multiplier.
module tb_case_9_mul_share_arb;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int BW = 3;
  localparam int DW = 4;
  localparam int IW = 2;

  logic              ap_clk = 1'b0;
  logic              ap_rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_a;
  logic [N*BW-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  case_9_mul_share_arb #(
    .NUM_REQ   (N),
    .ID_WIDTH  (IW),
    .DIN0_WIDTH(AW),
    .DIN1_WIDTH(BW),
    .DOUT_WIDTH(DW)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  always #5 ap_clk = ~ap_clk;

  // Reference model: ordered list of in-flight operations; an entry is visible
  // on the response port once it has spent one cycle past its handshake.
  typedef struct {
    int            id;
    logic [DW-1:0] data;
    bit            in_s2;
  } ent_t;

  ent_t pipe[$];
  int   ptr_m = 0;

  function automatic logic [DW-1:0] ref_mul(input logic [AW-1:0] a, input logic [BW-1:0] b);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    if (a[AW-1]) ai = ai - (1 << AW);
    if (b[BW-1]) bi = bi - (1 << BW);
    return DW'(ai * bi);
  endfunction

  function automatic int m_grant();
    int r;
    for (int k = 0; k < N; k++) begin
      r = (ptr_m + k) % N;
      if (req_valid[r]) return r;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int g;
    logic [N-1:0] v;
    g = m_grant();
    v = '0;
    if (!ap_rst && g >= 0 && (pipe.size() < 2 || rsp_ready)) v[g] = 1'b1;
    return v;
  endfunction

  function automatic bit m_rsp_valid();
    return pipe.size() > 0 && pipe[0].in_s2;
  endfunction

  task automatic m_edge();
    int   g;
    bit   hs;
    ent_t e;
    if (ap_rst) begin
      pipe.delete();
      ptr_m = 0;
      return;
    end
    g  = m_grant();
    hs = (m_ready() != '0);
    if (pipe.size() > 0 && pipe[0].in_s2 && rsp_ready) pipe.delete(0);
    if (pipe.size() > 0 && !pipe[0].in_s2) begin
      e       = pipe[0];
      e.in_s2 = 1'b1;
      pipe[0] = e;
    end
    if (hs) begin
      e.id    = g;
      e.data  = ref_mul(req_a[g*AW +: AW], req_b[g*BW +: BW]);
      e.in_s2 = 1'b0;
      pipe.push_back(e);
      ptr_m = (g + 1) % N;
    end
  endtask

  task automatic tick();
    m_edge();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic rand_ops();
    req_a = (N*AW)'($urandom);
    req_b = (N*BW)'($urandom);
  endtask

  task automatic test_reset();
    ap_rst    = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    rand_ops();
    tick();
    tick();
    #1;
    n_cmp++;
    if (req_ready !== '0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    ap_rst    = 1'b0;
    req_valid = '0;
    #1;
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_valid_busy: got %b%b want 00", rsp_valid, busy);
    end
    n_cmp++;
    if ({rsp_id, rsp_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_rsp: got id=%0d data=%h want 0/0", rsp_id, rsp_data);
    end
  endtask

  task automatic test_single();
    req_a = '0;
    req_b = '0;
    req_a[2*AW +: AW] = 4'd7;
    req_b[2*BW +: BW] = 3'd3;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 4'd5}) begin
      n_bad++;
      $display("FAIL single_rsp: got v=%b id=%0d data=%h want 1/2/5", rsp_valid, rsp_id, rsp_data);
    end
    tick();
  endtask

  task automatic test_corners();
    logic [AW-1:0] ca[4];
    logic [BW-1:0] cb[4];
    logic [DW-1:0] cr[4];
    ca = '{4'h8, 4'h8, 4'hf, 4'h5};
    cb = '{3'b100, 3'b011, 3'b111, 3'b110};
    cr = '{4'h0, 4'h8, 4'h1, 4'h6};
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      req_a[0 +: AW] = ca[i];
      req_b[0 +: BW] = cb[i];
      req_valid = 4'b0001;
      #1;
      n_cmp++;
      if (req_ready !== 4'b0001) begin
        n_bad++;
        $display("FAIL corner_ready[%0d]: got %b want 0001", i, req_ready);
      end
      tick();
      req_valid = '0;
      tick();
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, cr[i]}) begin
        n_bad++;
        $display("FAIL corner_rsp[%0d]: got v=%b id=%0d data=%h want 1/0/%h",
                 i, rsp_valid, rsp_id, rsp_data, cr[i]);
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] want;
    ap_rst    = 1'b1;
    req_valid = '0;
    tick();
    ap_rst    = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      req_valid = (i < 8) ? '1 : '0;
      #1;
      want = (i < 8) ? (N'(1) << (i % N)) : '0;
      n_cmp++;
      if (req_ready !== want) begin
        n_bad++;
        $display("FAIL fair_ready[%0d]: got %b want %b", i, req_ready, want);
      end
      if (i >= 2) begin
        n_cmp++;
        if ({rsp_valid, rsp_id} !== {1'b1, IW'((i - 2) % N)}) begin
          n_bad++;
          $display("FAIL fair_rsp_id[%0d]: got v=%b id=%0d want 1/%0d",
                   i, rsp_valid, rsp_id, (i - 2) % N);
        end
        n_cmp++;
        if (pipe.size() == 0 || rsp_data !== pipe[0].data) begin
          n_bad++;
          $display("FAIL fair_rsp_data[%0d]: got %h want %h", i, rsp_data,
                   (pipe.size() > 0) ? pipe[0].data : 4'hx);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int hs;
    int got;
    hs        = 0;
    got       = 0;
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      #1;
      if (req_ready != '0) hs++;
      n_cmp++;
      if (req_ready !== m_ready()) begin
        n_bad++;
        $display("FAIL bp_ready[%0d]: got %b want %b", i, req_ready, m_ready());
      end
      if (i >= 2) begin
        n_cmp++;
        if (pipe.size() == 0 || {rsp_valid, rsp_id, rsp_data} !== {1'b1, IW'(pipe[0].id), pipe[0].data}) begin
          n_bad++;
          $display("FAIL bp_hold[%0d]: got v=%b id=%0d data=%h", i, rsp_valid, rsp_id, rsp_data);
        end
      end
      tick();
    end
    n_cmp++;
    if (hs !== 2) begin
      n_bad++;
      $display("FAIL bp_handshakes: got %0d want 2", hs);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (rsp_valid) begin
        n_cmp++;
        if (pipe.size() == 0 || rsp_id !== IW'(got) || rsp_data !== pipe[0].data) begin
          n_bad++;
          $display("FAIL bp_drain[%0d]: got id=%0d data=%h want id=%0d", got, rsp_id, rsp_data, got);
        end
        got++;
      end
      tick();
    end
    n_cmp++;
    if (got !== 2) begin
      n_bad++;
      $display("FAIL bp_drain_count: got %0d want 2", got);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    req_valid = '1;
    rand_ops();
    tick();
    tick();
    #1;
    n_cmp++;
    if ({busy, rsp_valid, req_ready} !== {1'b1, 1'b1, 4'b0000}) begin
      n_bad++;
      $display("FAIL rmid_full: got busy=%b v=%b ready=%b want 1/1/0000", busy, rsp_valid, req_ready);
    end
    ap_rst = 1'b1;
    tick();
    ap_rst    = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    #1;
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL rmid_clear: got v=%b busy=%b want 0/0", rsp_valid, busy);
    end
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL rmid_grant: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_pointer_skip();
    logic [N-1:0] pat[3];
    logic [N-1:0] want[3];
    pat  = '{4'b1000, 4'b0010, 4'b0011};
    want = '{4'b1000, 4'b0010, 4'b0001};
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      req_valid = pat[i];
      #1;
      n_cmp++;
      if (req_ready !== want[i]) begin
        n_bad++;
        $display("FAIL ptr_skip[%0d]: got %b want %b", i, req_ready, want[i]);
      end
      tick();
    end
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ap_rst    = ($urandom_range(0, 63) == 0);
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      #1;
      n_cmp++;
      if (req_ready !== m_ready()) begin
        n_bad++;
        $display("FAIL rand_ready[%0d]: got %b want %b", i, req_ready, m_ready());
      end
      n_cmp++;
      if ({rsp_valid, busy} !== {m_rsp_valid(), pipe.size() > 0}) begin
        n_bad++;
        $display("FAIL rand_valid_busy[%0d]: got %b%b want %b%b", i, rsp_valid, busy,
                 m_rsp_valid(), pipe.size() > 0);
      end
      if (m_rsp_valid()) begin
        n_cmp++;
        if ({rsp_id, rsp_data} !== {IW'(pipe[0].id), pipe[0].data}) begin
          n_bad++;
          $display("FAIL rand_rsp[%0d]: got id=%0d data=%h want id=%0d data=%h",
                   i, rsp_id, rsp_data, pipe[0].id, pipe[0].data);
        end
      end
      tick();
    end
  endtask

  initial begin
    ap_rst    = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_corners();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_pointer_skip();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
